// File: rtl/spi_master_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_master_controller_pkg                                       |
// | Purpose  : Shared types and constants for the SPI master controller:       |
// |            FSM state encoding, frame width, counter widths and a helper    |
// |            that turns a cycle count into a terminal counter value.         |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package spi_master_controller_pkg;

  localparam int c_frame_w   = 8;   // address+R/W byte and data byte width
  localparam int c_bit_cnt_w = 4;   // per-byte bit counter
  localparam int c_cnt_w     = 16;  // divider, skip/hold and gap counters

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CS_SETUP = 4'd1,
    S_ADDR     = 4'd2,
    S_TURN     = 4'd3,
    S_RDATA    = 4'd4,
    S_WDATA    = 4'd5,
    S_HOLD     = 4'd6,
    S_END      = 4'd7,
    S_GAP      = 4'd8
  } state_e;

  // Terminal value for a counter running 0..n-1; n<=1 collapses to 0.
  function automatic logic [c_cnt_w-1:0] last_count(input int n);
    return (n > 1) ? c_cnt_w'(n - 1) : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_controller_sclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_sclk_gen                                                    |
// | Purpose  : SPI clock divider. While enabled, counts 0..CLK_DIV-1 and       |
// |            toggles sclk at the terminal count. The tick outputs are        |
// |            combinational and mark the clk edge on which sclk toggles, so   |
// |            the FSM acts on the same edge the pin changes.                  |
// | Ports    : clk, reset_n (async, active-low), i_en (run divider),           |
// |            o_sclk (idles low), o_rise_tick, o_fall_tick                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module spi_sclk_gen
  import spi_master_controller_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam logic [c_cnt_w-1:0] c_div_last = last_count(CLK_DIV);

  logic [c_cnt_w-1:0] div_cnt_q, div_cnt_d;
  logic               sclk_q, sclk_d;
  logic               w_tick;

  // Disabling clears both counter and sclk so every enable starts with a
  // full low half-period followed by a rise tick.
  always_comb begin
    w_tick    = i_en && (div_cnt_q == c_div_last);
    div_cnt_d = '0;
    sclk_d    = 1'b0;
    if (i_en) begin
      div_cnt_d = w_tick ? '0 : (div_cnt_q + c_cnt_w'(1));
      sclk_d    = w_tick ? ~sclk_q : sclk_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

  assign o_sclk      = sclk_q;
  assign o_rise_tick = w_tick & ~sclk_q;
  assign o_fall_tick = w_tick &  sclk_q;

endmodule
`default_nettype wire

// File: rtl/spi_master_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_master_controller                                           |
// | Purpose  : SPI master for single-byte memory transactions. Sends the       |
// |            {addr[6:0], rw} byte MSB first, then either shifts out write    |
// |            data and holds CS for the commit cycles, or idles through the   |
// |            slave turnaround and shifts in read data.                       |
// | Ports    : clk, reset_n (async, active-low)                                |
// |            req_valid/req_ready/req_rw/req_addr/req_wdata - request side    |
// |            rsp_valid/rsp_rdata - one-cycle completion, busy = ~req_ready   |
// |            spi_sclk/spi_cs/spi_mosi/spi_miso - SPI pins                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module spi_master_controller
  import spi_master_controller_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int RD_SKIP     = 3,
  parameter int WR_HOLD     = 2,
  parameter int CS_IDLE_CYC = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       spi_sclk,
  output logic       spi_cs,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [c_bit_cnt_w-1:0] c_last_bit     = c_bit_cnt_w'(c_frame_w - 1);
  localparam logic [c_cnt_w-1:0]     c_rd_skip_last = last_count(RD_SKIP);
  localparam logic [c_cnt_w-1:0]     c_wr_hold_last = last_count(WR_HOLD);
  localparam logic [c_cnt_w-1:0]     c_div_last     = last_count(CLK_DIV);
  localparam logic [c_cnt_w-1:0]     c_gap_last     = last_count(CS_IDLE_CYC);

  state_e                 state_q, state_d;
  logic                   cs_q, cs_d;
  logic                   mosi_q, mosi_d;
  logic [c_frame_w-1:0]   shift_out_q, shift_out_d;
  logic [c_frame_w-1:0]   shift_in_q, shift_in_d;
  logic [c_bit_cnt_w-1:0] bit_cnt_q, bit_cnt_d;
  logic [c_cnt_w-1:0]     skip_cnt_q, skip_cnt_d;
  logic [c_cnt_w-1:0]     gap_cnt_q, gap_cnt_d;
  logic                   rw_q, rw_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [7:0]             rsp_rdata_q, rsp_rdata_d;

  logic w_sclk_en;
  logic w_rise;
  logic w_fall;

  // sclk runs from CS setup through the last data/hold bit; END and GAP are
  // timed with the gap counter so sclk cannot produce a stray rise there.
  assign w_sclk_en = (state_q != S_IDLE) && (state_q != S_END) && (state_q != S_GAP);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_en        (w_sclk_en),
    .o_sclk      (spi_sclk),
    .o_rise_tick (w_rise),
    .o_fall_tick (w_fall)
  );

  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    mosi_d      = mosi_q;
    shift_out_d = shift_out_q;
    shift_in_d  = shift_in_q;
    bit_cnt_d   = bit_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rw_d        = req_rw;
          wdata_d     = req_wdata;
          // First frame bit goes straight to the pin; the rest queue up.
          mosi_d      = req_addr[6];
          shift_out_d = {req_addr[5:0], req_rw, 1'b0};
          cs_d        = 1'b0;
          bit_cnt_d   = '0;
          state_d     = S_CS_SETUP;
        end
      end

      // The first rise tick ends setup and is the first address-bit rise.
      S_CS_SETUP: begin
        if (w_rise) begin
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (w_fall) begin
          if (bit_cnt_q == c_last_bit) begin
            bit_cnt_d  = '0;
            skip_cnt_d = '0;
            if (rw_q) begin
              mosi_d  = 1'b0;
              state_d = (RD_SKIP > 0) ? S_TURN : S_RDATA;
            end else begin
              mosi_d      = wdata_q[7];
              shift_out_d = {wdata_q[6:0], 1'b0};
              state_d     = S_WDATA;
            end
          end else begin
            mosi_d      = shift_out_q[7];
            shift_out_d = {shift_out_q[6:0], 1'b0};
            bit_cnt_d   = bit_cnt_q + c_bit_cnt_w'(1);
          end
        end
      end

      S_TURN: begin
        if (w_fall) begin
          if (skip_cnt_q == c_rd_skip_last) begin
            skip_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = S_RDATA;
          end else begin
            skip_cnt_d = skip_cnt_q + c_cnt_w'(1);
          end
        end
      end

      S_RDATA: begin
        if (w_rise) begin
          shift_in_d = {shift_in_q[6:0], spi_miso};
        end
        if (w_fall) begin
          if (bit_cnt_q == c_last_bit) begin
            gap_cnt_d = '0;
            state_d   = S_END;
          end else begin
            bit_cnt_d = bit_cnt_q + c_bit_cnt_w'(1);
          end
        end
      end

      S_WDATA: begin
        if (w_fall) begin
          if (bit_cnt_q == c_last_bit) begin
            mosi_d     = 1'b0;
            skip_cnt_d = '0;
            gap_cnt_d  = '0;
            state_d    = (WR_HOLD > 0) ? S_HOLD : S_END;
          end else begin
            mosi_d      = shift_out_q[7];
            shift_out_d = {shift_out_q[6:0], 1'b0};
            bit_cnt_d   = bit_cnt_q + c_bit_cnt_w'(1);
          end
        end
      end

      S_HOLD: begin
        if (w_fall) begin
          if (skip_cnt_q == c_wr_hold_last) begin
            gap_cnt_d = '0;
            state_d   = S_END;
          end else begin
            skip_cnt_d = skip_cnt_q + c_cnt_w'(1);
          end
        end
      end

      // sclk stays low for one half-period before CS is released.
      S_END: begin
        if (gap_cnt_q == c_div_last) begin
          cs_d        = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rw_q ? shift_in_q : 8'h00;
          gap_cnt_d   = '0;
          state_d     = S_GAP;
        end else begin
          gap_cnt_d = gap_cnt_q + c_cnt_w'(1);
        end
      end

      S_GAP: begin
        if (gap_cnt_q == c_gap_last) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + c_cnt_w'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cs_q        <= 1'b1;
      mosi_q      <= 1'b0;
      shift_out_q <= '0;
      shift_in_q  <= '0;
      bit_cnt_q   <= '0;
      skip_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      shift_out_q <= shift_out_d;
      shift_in_q  <= shift_in_d;
      bit_cnt_q   <= bit_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign spi_cs    = cs_q;
  assign spi_mosi  = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire
